// File: rtl/gcd_core.sv
`timescale 1ns / 1ps
// gcd_core: iterative 32-bit unsigned GCD engine with a start/done level handshake.
// Build option GCD_MOD_STEP_EN selects a Euclid (remainder) step per cycle; when
// undefined, a binary (Stein) shift/subtract datapath is used and no divider is built.
// The result is held with done high until start is released; one computation per request.
module gcd_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    input  logic        start,
    output logic [31:0] result,
    output logic        done
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [5:0]  k_q, k_d;
    logic [31:0] result_q, result_d;
    logic        done_q, done_d;

`ifdef GCD_MOD_STEP_EN
    logic [31:0] rem;

    // Remainder step; the guard keeps the divider defined when b is zero.
    always_comb begin
        rem = '0;
        if (b_q != 32'd0) begin
            rem = a_q % b_q;
        end
    end
`endif

    // Next-state and datapath update for the three-state controller.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        k_d      = k_q;
        result_d = result_q;
        done_d   = done_q;

        case (state_q)
            StIdle: begin
                done_d = 1'b0;
                if (start) begin
                    a_d     = opa;
                    b_d     = opb;
                    k_d     = '0;
                    state_d = StBusy;
                end
            end

            StBusy: begin
`ifdef GCD_MOD_STEP_EN
                if (b_q == 32'd0) begin
                    result_d = a_q;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else begin
                    a_d = b_q;
                    b_d = rem;
                end
`else
                // Zero checks come first so gcd(0,0) exits before k can overflow.
                if (a_q == 32'd0) begin
                    result_d = b_q << k_q;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else if (b_q == 32'd0) begin
                    result_d = a_q << k_q;
                    done_d   = 1'b1;
                    state_d  = StDone;
                end else if (!a_q[0] && !b_q[0]) begin
                    a_d = a_q >> 1;
                    b_d = b_q >> 1;
                    k_d = k_q + 6'd1;
                end else if (!a_q[0]) begin
                    a_d = a_q >> 1;
                end else if (!b_q[0]) begin
                    b_d = b_q >> 1;
                end else if (a_q >= b_q) begin
                    // Both odd: the difference is even, so halve it in the same step.
                    a_d = (a_q - b_q) >> 1;
                end else begin
                    b_d = (b_q - a_q) >> 1;
                end
`endif
            end

            StDone: begin
                done_d = 1'b1;
                if (!start) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end

            default: begin
                done_d  = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            k_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            k_q      <= k_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_gcd_core.sv
`timescale 1ns / 1ps
// Self-checking bench for gcd_core: expected results are queued at issue time and a
// monitor compares them whenever done rises. Directed cases plus random operands.
module tb_gcd_core;

    logic        clk;
    logic        reset;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        start;
    logic [31:0] result;
    logic        done;

    int compared;
    int mismatched;
    logic [31:0] exp_q[$];

    gcd_core dut (
        .clk    (clk),
        .reset  (reset),
        .opa    (opa),
        .opb    (opb),
        .start  (start),
        .result (result),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain Euclid on unsigned integers.
    function automatic logic [31:0] ref_gcd(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] p, q, t;
        p = x;
        q = y;
        while (q != 32'd0) begin
            t = p % q;
            p = q;
            q = t;
        end
        return p;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    // Monitor: every rising done pops one expected result.
    initial begin
        logic done_prev;
        done_prev = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (done === 1'b1 && done_prev !== 1'b1) begin
                if (exp_q.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("FAIL unexpected_done: got result 0x%08h expected no completion",
                             result);
                end else begin
                    check("result", result, exp_q.pop_front());
                end
            end
            done_prev = done;
        end
    end

    // One full request: load, wait for done (bounded), hold, release start for one cycle.
    task automatic do_req(input logic [31:0] a, input logic [31:0] b, input bit scramble,
                          input int exp_lat);
        int          cyc;
        bit          got;
        logic [31:0] exp;
        exp = ref_gcd(a, b);
        @(negedge clk);
        opa   = a;
        opb   = b;
        start = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk);  // load edge
        cyc = 0;
        got = 1'b0;
        while (cyc < 200 && !got) begin
            @(posedge clk);
            #1;
            cyc++;
            if (done === 1'b1) got = 1'b1;
            if (scramble) begin
                opa = $urandom;
                opb = $urandom;
            end
        end
        check("done_seen", {31'd0, got}, 32'd1);
        if (got) begin
            check("latency_le_65", {31'd0, (cyc <= 65)}, 32'd1);
`ifdef GCD_MOD_STEP_EN
            if (exp_lat >= 0) check("euclid_latency", cyc, exp_lat);
`endif
            repeat (2) begin
                @(posedge clk);
                #1;
                check("hold_done", {31'd0, done}, 32'd1);
                check("hold_result", result, exp);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("done_clear", {31'd0, done}, 32'd0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        opa        = '0;
        opb        = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_done", {31'd0, done}, 32'd0);
        check("reset_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        do_req(32'd1071, 32'd462, 1'b0, 4);
        do_req(32'd0, 32'd35, 1'b0, -1);
        do_req(32'd48, 32'd0, 1'b0, -1);
        do_req(32'd0, 32'd0, 1'b0, -1);
        do_req(32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, -1);
        do_req(32'h8000_0000, 32'h4000_0000, 1'b0, -1);

        // Abort mid-computation: reset wins over a held start, no completion follows.
        @(negedge clk);
        opa   = 32'd1071;
        opb   = 32'd462;
        start = 1'b1;
        @(posedge clk);  // load edge
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check("abort_idle_done", {31'd0, done}, 32'd0);
        end
        do_req(32'd12, 32'd18, 1'b0, -1);

        // Back-to-back requests, second with operands disturbed during BUSY.
        do_req(32'd1071, 32'd462, 1'b0, 4);
        do_req(32'd17, 32'd5, 1'b1, -1);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y, g;
            case (i % 4)
                0: begin
                    x = $urandom;
                    y = $urandom;
                end
                1: begin
                    g = $urandom_range(1, 1000);
                    x = g * $urandom_range(0, 100000);
                    y = g * $urandom_range(0, 100000);
                end
                2: begin
                    x = $urandom << $urandom_range(0, 20);
                    y = $urandom << $urandom_range(0, 20);
                end
                default: begin
                    x = $urandom_range(0, 64);
                    y = $urandom_range(0, 64);
                end
            endcase
            do_req(x, y, (i % 3) == 0, -1);
        end

        repeat (2) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
